// File: rtl/ps2_keycode_rx.sv
// PS/2 set-2 keyboard receiver: syncs and filters the PS/2 lines,
// frames 11-bit words, decodes make/break/E0/F0 into keycode/press.
// Ports: clk, reset (sync, high); ps2_clk, ps2_data (raw async in);
// keycode[7:0], press, extended, code_valid (pulse), frame_err (pulse).
`timescale 1ns/1ps
module ps2_keycode_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       press,
  output logic       extended,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {F_IDLE, F_DATA, F_PAR, F_STOP} fst_t;
  typedef enum logic {D_NORM, D_BRK} dst_t;

  logic clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FILTER_LEN-1:0] hist;
  logic filt, fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      hist   <= '1;
      filt   <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
      hist   <= {hist[FILTER_LEN-2:0], clk_s2};
      if (&hist)       filt <= 1'b1;
      else if (~|hist) filt <= 1'b0;
    end
  end

  // Edge fires on the cycle the filter accepts a new low level.
  assign fall = filt & ~|hist;

  fst_t fst, fst_nx;
  logic [7:0] shift, rx_byte;
  logic [2:0] bitcnt;
  logic par, byte_rdy, rdy_c, err_c, tmo;
  logic [TW-1:0] tcnt;

  // A coincident edge takes priority over the timeout.
  assign tmo = !fall && (fst != F_IDLE) && (tcnt == TLAST);

  always_ff @(posedge clk) begin
    if (reset) fst <= F_IDLE;
    else       fst <= fst_nx;
  end

  always_comb begin
    fst_nx = fst;
    if (tmo) fst_nx = F_IDLE;
    else if (fall) begin
      case (fst)
        F_IDLE: if (!dat_s2) fst_nx = F_DATA;
        F_DATA: if (bitcnt == 3'd7) fst_nx = F_PAR;
        F_PAR:  fst_nx = F_STOP;
        F_STOP: fst_nx = F_IDLE;
        default: fst_nx = F_IDLE;
      endcase
    end
  end

  always_comb begin
    rdy_c = 1'b0;
    err_c = tmo;
    if (fall && fst == F_IDLE && dat_s2) err_c = 1'b1;
    if (fall && fst == F_STOP) begin
      if (dat_s2 && (^{shift, par})) rdy_c = 1'b1;
      else                           err_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift     <= '0;
      bitcnt    <= '0;
      par       <= 1'b0;
      tcnt      <= '0;
      byte_rdy  <= 1'b0;
      frame_err <= 1'b0;
      rx_byte   <= '0;
    end else begin
      byte_rdy  <= rdy_c;
      frame_err <= err_c;
      if (rdy_c) rx_byte <= shift;
      if (fall || fst == F_IDLE) tcnt <= '0;
      else                       tcnt <= tcnt + TW'(1);
      if (fall) begin
        case (fst)
          F_IDLE: bitcnt <= '0;
          F_DATA: begin
            shift  <= {dat_s2, shift[7:1]};
            bitcnt <= bitcnt + 3'd1;
          end
          F_PAR:  par <= dat_s2;
          default: ;
        endcase
      end
    end
  end

  dst_t dst, dst_nx;
  logic ext_pend, ign, is_make, hit;
  logic set_ext, clr_ext;

  assign ign = rx_byte inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  always_ff @(posedge clk) begin
    if (reset) dst <= D_NORM;
    else       dst <= dst_nx;
  end

  always_comb begin
    dst_nx = dst;
    if (byte_rdy) begin
      if (dst == D_BRK)            dst_nx = D_NORM;
      else if (rx_byte == 8'hF0)   dst_nx = D_BRK;
    end
  end

  always_comb begin
    is_make = 1'b0;
    hit     = 1'b0;
    set_ext = 1'b0;
    clr_ext = 1'b0;
    if (byte_rdy) begin
      if (dst == D_BRK) begin
        hit     = (rx_byte == keycode) && (ext_pend == extended);
        clr_ext = 1'b1;
      end else if (rx_byte == 8'hE0) begin
        set_ext = 1'b1;
      end else if (rx_byte != 8'hF0) begin
        is_make = !ign;
        clr_ext = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      keycode    <= '0;
      press      <= 1'b0;
      extended   <= 1'b0;
      code_valid <= 1'b0;
      ext_pend   <= 1'b0;
    end else begin
      code_valid <= is_make | hit;
      if (set_ext)      ext_pend <= 1'b1;
      else if (clr_ext) ext_pend <= 1'b0;
      if (is_make) begin
        keycode  <= rx_byte;
        extended <= ext_pend;
        press    <= 1'b1;
      end else if (hit) begin
        press    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Scoreboard bench for ps2_keycode_rx: directed PS/2 frames with
// expected keycode/press/extended and frame_err pulses queued ahead.
`timescale 1ns/1ps
module tb_ps2_keycode_rx;
  localparam int H  = 20;
  localparam int TO = 400;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic [7:0] keycode;
  logic press, extended, code_valid, frame_err;

  typedef struct packed {
    logic [7:0] k;
    logic p;
    logic e;
  } exp_t;

  exp_t cq[$];
  exp_t x;
  int err_exp = 0;
  int n_chk = 0;
  int n_bad = 0;
  logic glitch = 1'b0;

  always #10 clk = ~clk;

  ps2_keycode_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keycode(keycode), .press(press), .extended(extended),
    .code_valid(code_valid), .frame_err(frame_err)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (code_valid) begin
        n_chk++;
        if (cq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_code_valid: got %h/%b/%b required none",
                   keycode, press, extended);
        end else begin
          x = cq.pop_front();
          if ({keycode, press, extended} !== x) begin
            n_bad++;
            $display("FAIL code: got %h/%b/%b required %h/%b/%b",
                     keycode, press, extended, x.k, x.p, x.e);
          end
        end
      end
      if (frame_err) begin
        n_chk++;
        if (err_exp == 0) begin
          n_bad++;
          $display("FAIL unexpected_frame_err: got 1 required 0");
        end else begin
          err_exp--;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] req);
    n_chk++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, got, req);
    end
  endtask

  task automatic push(input logic [7:0] k, input logic p, input logic e);
    cq.push_back({k, p, e});
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (H/2) @(negedge clk);
    if (glitch) begin
      ps2_clk = 1'b0;
      @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (H/2) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H/2) @(negedge clk);
    if (glitch) begin
      ps2_clk = 1'b1;
      @(negedge clk);
      ps2_clk = 1'b0;
    end
    repeat (H/2) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par,
                            input logic bad_stop, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  task automatic cp(input string nm, input logic [7:0] k,
                    input logic p, input logic e);
    repeat (60) @(negedge clk);
    chk({nm, "_pending_codes"}, cq.size(), 0);
    chk({nm, "_pending_errs"}, err_exp, 0);
    chk({nm, "_outputs"}, {keycode, press, extended}, {k, p, e});
  endtask

  initial begin
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {keycode, press, extended}, 10'h000);
    chk("reset_pulses", {code_valid, frame_err}, 2'b00);

    push(8'h29, 1'b1, 1'b0);
    send(8'h29);
    cp("make_29", 8'h29, 1'b1, 1'b0);

    push(8'h29, 1'b0, 1'b0);
    send(8'hF0); send(8'h29);
    cp("break_29", 8'h29, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      push(8'h29, 1'b1, 1'b0);
      send(8'h29);
      chk("typematic_press", press, 1'b1);
    end
    cp("typematic", 8'h29, 1'b1, 1'b0);

    push(8'h75, 1'b1, 1'b1);
    send(8'hE0); send(8'h75);
    cp("make_e075", 8'h75, 1'b1, 1'b1);
    push(8'h75, 1'b0, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h75);
    cp("break_e075", 8'h75, 1'b0, 1'b1);

    push(8'h75, 1'b1, 1'b1);
    send(8'hE0); send(8'h75);
    send(8'hF0); send(8'h75);
    cp("bare_break_ignored", 8'h75, 1'b1, 1'b1);

    send(8'hAA);
    cp("bat_ignored", 8'h75, 1'b1, 1'b1);

    err_exp++;
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    cp("bad_parity", 8'h75, 1'b1, 1'b1);
    err_exp++;
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    cp("bad_stop", 8'h75, 1'b1, 1'b1);

    err_exp++;
    send_frame(8'h1C, 1'b0, 1'b0, 6);
    repeat (TO + 50) @(negedge clk);
    cp("timeout", 8'h75, 1'b1, 1'b1);
    push(8'h1C, 1'b1, 1'b0);
    send(8'h1C);
    cp("after_timeout", 8'h1C, 1'b1, 1'b0);

    send_frame(8'h29, 1'b0, 1'b0, 5);
    ps2_data = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H/2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midframe_reset_outs", {keycode, press, extended}, 10'h000);
    chk("midframe_reset_pulses", {code_valid, frame_err}, 2'b00);
    push(8'h29, 1'b1, 1'b0);
    send(8'h29);
    cp("after_reset", 8'h29, 1'b1, 1'b0);

    glitch = 1'b1;
    push(8'h1C, 1'b1, 1'b0);
    send(8'h1C);
    push(8'h5A, 1'b1, 1'b0);
    send(8'h5A);
    glitch = 1'b0;
    cp("glitch", 8'h5A, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
